contador_comparador_param: RTL

Parametrised counter/comparator datapath with up/down counting and a programmable modulus, plus an internal reference register loaded from the switch inputs. Each cycle the count is compared against that stored reference. Adds a registered equality-edge pulse and a sticky match flag. Intended as the reusable datapath under the next experiments' control units, replacing the fixed 4-bit counter + comparator pair.

---
 rtl/contador_comparador_param.sv | 97 +++++++++
 1 files changed

// File: rtl/contador_comparador_param.sv
// Parametrised up/down modulo-M counter with a reference register, magnitude compare, equality-edge pulse and sticky match flag.
// Latency: count/reference update 1 edge after sampling; compare/fim combinational from registers; igual_pulso +1 edge, atingiu +2 edges.
// Backpressure: none; every control input is acted on at every rising edge.
//
// Ports:
//   clock, zera_n        : rising-edge clock, asynchronous active-low reset
//   zera                 : synchronous clear of count and sticky flag
//   carrega, registra    : load count / reference from chaves (clamped to M-1)
//   conta, desce         : count enable and direction (0 = up, 1 = down)
//   chaves               : N-bit data for loads
//   contagem, referencia : registered count and reference
//   menor, maior, igual  : unsigned compare of contagem against referencia
//   fim                  : terminal count for the current direction
//   igual_pulso, atingiu : one-cycle pulse on igual rising, sticky match flag
module contador_comparador_param #(
  parameter int N = 4,
  parameter int M = 16
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         zera,
  input  logic         carrega,
  input  logic         registra,
  input  logic         conta,
  input  logic         desce,
  input  logic [N-1:0] chaves,
  output logic [N-1:0] contagem,
  output logic [N-1:0] referencia,
  output logic         menor,
  output logic         maior,
  output logic         igual,
  output logic         fim,
  output logic         igual_pulso,
  output logic         atingiu
);

  localparam logic [N-1:0] MAX   = N'(M - 1);
  // One extra bit so M = 2^N is representable in the clamp compare.
  localparam logic [N:0]   M_EXT = (N + 1)'(M);

  logic [N-1:0] chaves_clamp;
  logic         no_topo;
  logic         no_zero;
  logic         igual_d;

  // Out-of-range switch values saturate to the top of the count range.
  assign chaves_clamp = ({1'b0, chaves} >= M_EXT) ? MAX : chaves;

  assign no_topo = (contagem == MAX);
  assign no_zero = (contagem == '0);

  assign menor = (contagem <  referencia);
  assign maior = (contagem >  referencia);
  assign igual = (contagem == referencia);

  assign fim = conta & ((~desce & no_topo) | (desce & no_zero));

  // Count register: zera > carrega > conta > hold.
  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (carrega) begin
      contagem <= chaves_clamp;
    end else if (conta) begin
      if (desce) begin
        contagem <= no_zero ? MAX : contagem - 1'b1;
      end else begin
        contagem <= no_topo ? '0 : contagem + 1'b1;
      end
    end
  end

  // Reference register is independent of the count priority and survives zera.
  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      referencia <= '0;
    end else if (registra) begin
      referencia <= chaves_clamp;
    end
  end

  // igual_d resets to 1 so the reset state (0 == 0) does not look like a new match.
  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      igual_d     <= 1'b1;
      igual_pulso <= 1'b0;
      atingiu     <= 1'b0;
    end else begin
      igual_d     <= igual;
      igual_pulso <= igual & ~igual_d;
      atingiu     <= zera ? 1'b0 : (atingiu | igual_pulso);
    end
  end

endmodule
